fetch_sequencer: RTL

Drives the PC-control side of the PC interface. Fetches one instruction per handshake from instruction memory and holds it in an instruction register. Decodes the PC-control fields (BrEq, BrNeq, RegToPc, Jump, Halt, imm, addr) from that register and strobes the PC advance once the datapath reports the instruction complete. Sits between the instruction-memory port and the PC unit, which consumes its outputs together with alu_zero and rdat from the datapath.

---
 rtl/cpu_types_pkg.sv | 37 +++
 rtl/fetch_sequencer_if.sv | 34 +++
 rtl/pc_ctrl_decode.sv | 25 ++
 rtl/fetch_sequencer.sv | 92 +++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU types for the fetch sequencer: word type, field widths,
// opcode/funct encodings and the sequencer state type.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int IMM_W  = 16;
  localparam int ADDR_W = 26;

  typedef enum logic [5:0] {
    RTYPE = 6'h00,
    J     = 6'h02,
    JAL   = 6'h03,
    BEQ   = 6'h04,
    BNE   = 6'h05,
    HALT  = 6'h3F
  } opcode_t;

  typedef enum logic [5:0] {
    JR = 6'h08
  } funct_t;

  typedef enum logic [1:0] {
    FETCH,
    ISSUE,
    HALTED
  } fetch_state_t;

  typedef struct packed {
    logic breq;
    logic brneq;
    logic regtopc;
    logic jump;
    logic halt;
  } pc_ctrl_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory / datapath / PC-control signal bundle of the fetch sequencer.
interface fetch_sequencer_if #(
    parameter int RETIRE_W = 32
) ();

    logic                               ihit;
    cpu_types_pkg::word_t               imemload;
    logic                               ex_done;
    logic                               imemREN;
    cpu_types_pkg::word_t               instr;
    logic                               instr_valid;
    logic                               pc_en;
    logic                               BrEq;
    logic                               BrNeq;
    logic                               RegToPc;
    logic                               Jump;
    logic                               Halt;
    logic [cpu_types_pkg::IMM_W-1:0]    imm;
    logic [cpu_types_pkg::ADDR_W-1:0]   addr;
    logic [RETIRE_W-1:0]                retired;

    modport master (
        input  ihit, imemload, ex_done,
        output imemREN, instr, instr_valid, pc_en,
               BrEq, BrNeq, RegToPc, Jump, Halt, imm, addr, retired
    );

    modport slave (
        output ihit, imemload, ex_done,
        input  imemREN, instr, instr_valid, pc_en,
               BrEq, BrNeq, RegToPc, Jump, Halt, imm, addr, retired
    );

endinterface

// File: rtl/pc_ctrl_decode.sv
// Purely combinational decode of an instruction word into the PC control bits.
module pc_ctrl_decode
    import cpu_types_pkg::*;
(
    input  word_t    i_instr,
    output pc_ctrl_t o_ctrl
);

    // Only opcode and funct matter to PC control.
    logic w_unused;
    assign w_unused = ^i_instr[25:6];

    always_comb begin
        o_ctrl = '0;
        case (i_instr[31:26])
            BEQ:    o_ctrl.breq    = 1'b1;
            BNE:    o_ctrl.brneq   = 1'b1;
            J, JAL: o_ctrl.jump    = 1'b1;
            HALT:   o_ctrl.halt    = 1'b1;
            RTYPE:  o_ctrl.regtopc = (i_instr[5:0] == JR);
            default: o_ctrl = '0;
        endcase
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/issue sequencer: holds the instruction register, decodes PC control,
// strobes the PC advance on completion and counts retired instructions.
module fetch_sequencer
    import cpu_types_pkg::*;
#(
    parameter int RETIRE_W = 32
) (
    input logic               CLK,
    input logic               RST,
    fetch_sequencer_if.master bus
);

    fetch_state_t        r_state;
    word_t               r_instr;
    logic [RETIRE_W-1:0] r_retired;
    logic                r_imemREN;

    pc_ctrl_t w_dec;
    pc_ctrl_t w_ctrl;
    logic     w_issue;
    logic     w_pc_en;

    pc_ctrl_decode u_decode (
        .i_instr (r_instr),
        .o_ctrl  (w_dec)
    );

    assign w_issue = (r_state == ISSUE);
    assign w_pc_en = w_issue && !w_dec.halt && bus.ex_done;

    always_comb begin
        w_ctrl = w_issue ? w_dec : '0;
        if (r_state == HALTED) begin
            w_ctrl.halt = 1'b1;
        end
    end

    // imemREN is registered so all outputs read 0 during reset; a FETCH cycle
    // with imemREN still low (first cycle out of reset) ignores ihit.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state   <= FETCH;
            r_instr   <= '0;
            r_retired <= '0;
            r_imemREN <= 1'b0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (r_imemREN && bus.ihit) begin
                        r_instr   <= bus.imemload;
                        r_state   <= ISSUE;
                        r_imemREN <= 1'b0;
                    end else begin
                        r_imemREN <= 1'b1;
                    end
                end
                ISSUE: begin
                    if (w_dec.halt) begin
                        r_state   <= HALTED;
                        r_retired <= r_retired + 1'b1;
                        r_imemREN <= 1'b0;
                    end else if (bus.ex_done) begin
                        r_state   <= FETCH;
                        r_retired <= r_retired + 1'b1;
                        r_imemREN <= 1'b1;
                    end
                end
                HALTED: begin
                    r_imemREN <= 1'b0;
                end
                default: begin
                    r_state   <= FETCH;
                    r_imemREN <= 1'b0;
                end
            endcase
        end
    end

    assign bus.imemREN     = r_imemREN;
    assign bus.instr       = r_instr;
    assign bus.instr_valid = w_issue;
    assign bus.pc_en       = w_pc_en;
    assign bus.BrEq        = w_ctrl.breq;
    assign bus.BrNeq       = w_ctrl.brneq;
    assign bus.RegToPc     = w_ctrl.regtopc;
    assign bus.Jump        = w_ctrl.jump;
    assign bus.Halt        = w_ctrl.halt;
    assign bus.imm         = r_instr[IMM_W-1:0];
    assign bus.addr        = r_instr[ADDR_W-1:0];
    assign bus.retired     = r_retired;

endmodule
